// File: rtl/pipelined_ripple_adder_pkg.sv
// Shared types and helpers for the pipelined ripple adder.
// Stage control bundle and slice-count derivation.
package pipelined_ripple_adder_pkg;

    typedef struct packed {
        logic vld;
        logic c;
        logic v;
    } ctl_t;

    function automatic bit geom_ok(input int w, input int sw);
        if (sw < 1) return 1'b0;
        return (w % sw == 0) && (w >= sw);
    endfunction

    function automatic int nstages(input int w, input int sw);
        return geom_ok(w, sw) ? w / sw : 1;
    endfunction

endpackage

// File: rtl/pipelined_ripple_adder_if.sv
// Operand/result streaming bundle for the pipelined ripple adder.
// master = operand source / result sink, slave = adder.
interface pipelined_ripple_adder_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/adder_slice.sv
// STAGE_W-bit ripple slice built from full_adder cells.
// Exposes the carry into the MSB so the last slice can form ovf.
module adder_slice #(
    parameter int W = 2
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co,
    output logic         cm
);
    for (genvar i = 0; i < W; i++) begin : g_fa
        logic cin_i;
        logic co_i;
        if (i == 0) begin : g_c0
            assign cin_i = ci;
        end else begin : g_cn
            assign cin_i = g_fa[i-1].co_i;
        end
        full_adder u_fa (
            .a  (a[i]),
            .b  (b[i]),
            .ci (cin_i),
            .s  (s[i]),
            .co (co_i)
        );
    end

    assign co = g_fa[W-1].co_i;
    assign cm = g_fa[W-1].cin_i;
endmodule

module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/pipelined_ripple_adder.sv
// Pipelined add/subtract: one STAGE_W ripple slice per register stage,
// carry travels with the beat, whole pipe stalls on output backpressure.
module pipelined_ripple_adder
    import pipelined_ripple_adder_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int STAGE_W = 2
) (
    input logic                     clk,
    input logic                     rst_n,
    pipelined_ripple_adder_if.slave io
);
    localparam int NS = nstages(WIDTH, STAGE_W);

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] s;
        ctl_t             ctl;
    } stage_t;

    if (!geom_ok(WIDTH, STAGE_W)) begin : g_bad
        $error("pipelined_ripple_adder: WIDTH must be a multiple of STAGE_W >= 1");
    end

    logic   adv;
    stage_t pipe [NS];
    stage_t last;
    logic   unused_ops;

    for (genvar k = 0; k < NS; k++) begin : g_st
        stage_t             prv;
        stage_t             nxt;
        logic [STAGE_W-1:0] ss;
        logic               sc;
        logic               scm;

        if (k == 0) begin : g_in
            always_comb begin
                prv         = '0;
                prv.a       = io.a;
                prv.b       = io.sub ? ~io.b : io.b;
                prv.ctl.vld = io.in_valid;
                prv.ctl.c   = io.sub | io.cin;
            end
        end else begin : g_mid
            assign prv = pipe[k-1];
        end

        adder_slice #(.W(STAGE_W)) u_slice (
            .a  (prv.a[k*STAGE_W +: STAGE_W]),
            .b  (prv.b[k*STAGE_W +: STAGE_W]),
            .ci (prv.ctl.c),
            .s  (ss),
            .co (sc),
            .cm (scm)
        );

        // ovf is only meaningful once the MSB slice has run
        always_comb begin
            nxt                         = prv;
            nxt.s[k*STAGE_W +: STAGE_W] = ss;
            nxt.ctl.c                   = sc;
            nxt.ctl.v                   = scm ^ sc;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                pipe[k] <= '0;
            end else if (adv) begin
                pipe[k] <= nxt;
            end
        end
    end

    assign last         = pipe[NS-1];
    assign adv          = !last.ctl.vld || io.out_ready;
    assign io.in_ready  = adv;
    assign io.out_valid = last.ctl.vld;
    assign io.sum       = last.s;
    assign io.cout      = last.ctl.c;
    assign io.ovf       = last.ctl.v;
    assign unused_ops   = ^{last.a, last.b};
endmodule

// File: tb/tb_pipelined_ripple_adder.sv
// Directed and random streaming bench for pipelined_ripple_adder.
// 8/2 directed instance plus 16/16 and 32/4 random sweep instances.
module tb_pipelined_ripple_adder;
    logic clk;
    logic rst_n;
    logic sweep_go;
    int   n_chk = 0;
    int   n_bad = 0;
    int   n_out = 0;
    int   base;
    logic saw;
    logic [65:0] q8 [$];

    pipelined_ripple_adder_if #(.WIDTH(8)) i8 ();

    pipelined_ripple_adder #(.WIDTH(8), .STAGE_W(2)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (i8.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [65:0] got,
                       input logic [65:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // independent arithmetic reference: {ovf, cout, sum}
    function automatic logic [65:0] ref_add(input logic [63:0] a,
            input logic [63:0] b, input logic cin, input logic sub,
            input int w);
        logic [64:0] m, bb, t;
        logic [63:0] s;
        logic        co, ov;
        m  = (65'd1 << w) - 65'd1;
        bb = (sub ? ~{1'b0, b} : {1'b0, b}) & m;
        t  = ({1'b0, a} & m) + bb + (sub ? 65'd1 : {64'd0, cin});
        s  = t[63:0] & m[63:0];
        co = t[w];
        ov = (a[w-1] == bb[w-1]) && (s[w-1] != a[w-1]);
        return {ov, co, s};
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            q8.delete();
        end else begin
            if (i8.out_valid && i8.out_ready) begin
                n_out <= n_out + 1;
                if (q8.size() == 0) chk("spur8", 66'(1), 66'(0));
                else chk("sb8", {i8.ovf, i8.cout, 64'(i8.sum)}, q8.pop_front());
            end
            if (i8.in_valid && i8.in_ready)
                q8.push_back(ref_add(64'(i8.a), 64'(i8.b), i8.cin, i8.sub, 8));
        end
    end

    task automatic send8(input logic [7:0] a, input logic [7:0] b,
                         input logic cin, input logic sub);
        logic acc;
        int   n;
        i8.a = a; i8.b = b; i8.cin = cin; i8.sub = sub;
        i8.in_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            acc = i8.in_ready;
            @(posedge clk); #1;
            n++;
        end while (!acc && n < 200);
        if (!acc) chk("acc8_to", 66'(0), 66'(1));
        i8.in_valid = 1'b0;
    endtask

    task automatic run_one(input logic [7:0] a, input logic [7:0] b,
                           input logic cin, input logic sub,
                           input logic [9:0] exp);
        int n;
        i8.out_ready = 1'b1;
        i8.a = a; i8.b = b; i8.cin = cin; i8.sub = sub;
        i8.in_valid = 1'b1;
        @(posedge clk); #1;
        i8.in_valid = 1'b0;
        n = 1;
        while (!i8.out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("lat8", 66'(n), 66'(4));
        chk("res8", 66'({i8.ovf, i8.cout, i8.sum}), 66'(exp));
        @(posedge clk); #1;
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_sw
        localparam int W  = (g == 0) ? 16 : 32;
        localparam int SW = (g == 0) ? 16 : 4;
        logic        done;
        logic [65:0] q [$];

        pipelined_ripple_adder_if #(.WIDTH(W)) io ();

        pipelined_ripple_adder #(.WIDTH(W), .STAGE_W(SW)) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .io    (io.slave)
        );

        always @(negedge clk) begin
            if (!rst_n) begin
                q.delete();
            end else begin
                if (io.out_valid && io.out_ready) begin
                    if (q.size() == 0) chk("spur_sw", 66'(1), 66'(0));
                    else chk(g == 0 ? "sw16" : "sw32",
                             {io.ovf, io.cout, 64'(io.sum)}, q.pop_front());
                end
                if (io.in_valid && io.in_ready)
                    q.push_back(ref_add(64'(io.a), 64'(io.b), io.cin, io.sub, W));
            end
        end

        initial begin
            automatic int   n;
            automatic logic acc;
            done = 1'b0;
            io.in_valid = 1'b0; io.a = '0; io.b = '0;
            io.cin = 1'b0; io.sub = 1'b0; io.out_ready = 1'b1;
            wait (sweep_go);
            @(posedge clk); #1;
            io.a = W'(64'h8000_0001_8000_0001);
            io.b = W'(64'h7fff_ffff_7fff_ffff);
            io.in_valid = 1'b1;
            @(posedge clk); #1;
            io.in_valid = 1'b0;
            n = 1;
            while (!io.out_valid && n < 40) begin
                @(posedge clk); #1;
                n++;
            end
            chk(g == 0 ? "lat16" : "lat32", 66'(n), 66'(W / SW));
            @(posedge clk); #1;
            for (int i = 0; i < 10000; i++) begin
                io.a   = W'({$urandom, $urandom});
                io.b   = W'({$urandom, $urandom});
                io.cin = 1'($urandom);
                io.sub = 1'($urandom);
                io.in_valid = 1'b1;
                n = 0;
                do begin
                    io.out_ready = ($urandom_range(3) != 0);
                    @(negedge clk);
                    acc = io.in_ready;
                    @(posedge clk); #1;
                    n++;
                end while (!acc && n < 1000);
                if (!acc) chk("acc_sw_to", 66'(0), 66'(1));
                io.in_valid = 1'b0;
                if ($urandom_range(3) == 0) begin
                    io.out_ready = 1'($urandom);
                    @(posedge clk); #1;
                end
            end
            io.out_ready = 1'b1;
            n = 0;
            while (q.size() != 0 && n < 100) begin
                @(posedge clk); #1;
                n++;
            end
            chk("drain_sw", 66'(q.size()), 66'(0));
            done = 1'b1;
        end
    end

    initial begin
        rst_n = 1'b0; sweep_go = 1'b0;
        i8.in_valid = 1'b0; i8.a = '0; i8.b = '0;
        i8.cin = 1'b0; i8.sub = 1'b0; i8.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_vld", 66'(i8.out_valid), 66'(0));
        chk("rst_out", 66'({i8.ovf, i8.cout, i8.sum}), 66'(0));
        chk("rst_rdy", 66'(i8.in_ready), 66'(1));
        i8.out_ready = 1'b1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_one(8'hff, 8'h01, 1'b0, 1'b0, 10'h100);
        run_one(8'h7f, 8'h01, 1'b0, 1'b0, 10'h280);
        run_one(8'h05, 8'h07, 1'b0, 1'b1, 10'h0fe);
        run_one(8'h80, 8'h01, 1'b0, 1'b1, 10'h37f);
        run_one(8'h0f, 8'h10, 1'b1, 1'b0, 10'h020);

        // 16 back-to-back beats at full rate
        base = n_out;
        fork
            for (int i = 0; i < 16; i++)
                send8(8'(i * 37 + 5), 8'(i * 91 + 11), i[0], i[1]);
            begin
                automatic int k = 0;
                automatic int run = 0;
                while (!i8.out_valid && k < 40) begin
                    @(posedge clk); #1;
                    k++;
                end
                while (i8.out_valid && run < 40) begin
                    run++;
                    @(posedge clk); #1;
                end
                chk("s16_run", 66'(run), 66'(16));
            end
        join
        chk("s16_n", 66'(n_out - base), 66'(16));
        chk("s16_q", 66'(q8.size()), 66'(0));

        // three-cycle output stall mid-stream
        base = n_out;
        fork
            for (int i = 0; i < 10; i++)
                send8(8'(i * 23 + 200), 8'(i * 59 + 7), i[0], i[2]);
            begin
                automatic logic [9:0] snap;
                repeat (6) @(posedge clk);
                #1;
                i8.out_ready = 1'b0;
                #1;
                chk("st_vld", 66'(i8.out_valid), 66'(1));
                snap = {i8.ovf, i8.cout, i8.sum};
                repeat (3) begin
                    chk("st_rdy", 66'(i8.in_ready), 66'(0));
                    @(posedge clk); #1;
                    chk("st_hold", 66'({i8.ovf, i8.cout, i8.sum}), 66'(snap));
                end
                i8.out_ready = 1'b1;
            end
        join
        for (int k = 0; k < 60 && (n_out - base) < 10; k++) @(posedge clk);
        #1;
        chk("st_n", 66'(n_out - base), 66'(10));
        chk("st_q", 66'(q8.size()), 66'(0));

        // reset with beats in flight
        send8(8'h11, 8'h22, 1'b0, 1'b0);
        send8(8'h33, 8'h44, 1'b1, 1'b0);
        send8(8'h55, 8'h66, 1'b0, 1'b1);
        @(posedge clk); #1;
        chk("pre_rst", 66'(i8.out_valid), 66'(1));
        rst_n = 1'b0;
        #1;
        chk("rst_async", 66'(i8.out_valid), 66'(0));
        chk("rst_clr", 66'({i8.ovf, i8.cout, i8.sum}), 66'(0));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        saw = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            saw = saw | i8.out_valid;
        end
        chk("no_stale", 66'(saw), 66'(0));
        run_one(8'h10, 8'h20, 1'b0, 1'b0, 10'h030);

        sweep_go = 1'b1;
        for (int k = 0; k < 60000 && !(g_sw[0].done && g_sw[1].done); k++)
            @(posedge clk);
        chk("sweep_done", 66'({g_sw[0].done, g_sw[1].done}), 66'(3));

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/pipelined_ripple_adder.md
Name: pipelined_ripple_adder

Overview:
Parametrised, pipelined successor to the team's 8-bit ripple-carry adder. A WIDTH-bit add/subtract is split into NSTAGES = WIDTH/STAGE_W ripple slices, with one register stage per slice. The carry ripples between pipeline stages, so one operation is accepted per cycle. Valid/ready streaming handshake with backpressure; signed-overflow flag; sits in the datapath between the operand source and the ALU result mux.

Parameters:
WIDTH, 8, operand/result width in bits; must be a multiple of STAGE_W.
STAGE_W, 2, bits added per pipeline stage; STAGE_W = WIDTH gives a single-stage registered adder.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand beat present
in_ready  output  1  block accepts beat this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry-in; used only when sub=0
sub  input  1  1 = A - B, 0 = A + B + cin
out_valid  output  1  result beat present
out_ready  input  1  sink accepts result
sum  output  WIDTH  result
cout  output  1  carry-out; for sub=1 this is the no-borrow flag (1 when A >= B unsigned)
ovf  output  1  two's-complement overflow

Behaviour:
- Reset is asynchronous, active-low, fixed: while rst_n=0, clear all stage valid bits, sum=0, cout=0, ovf=0 and out_valid=0. Data registers also clear to 0.
- Operand preparation at input: bb = sub ? ~b : b; c0 = sub ? 1 : cin.
- Pipeline control:
  - advance = !vld[NSTAGES-1] || out_ready.
  - All stages move together when advance=1; the whole pipe holds when advance=0.
  - in_ready = advance; this is combinational, with no dependence on in_valid.
- Transfer rules:
  - An input beat is accepted when in_valid && in_ready.
  - Stage 0 valid loads in_valid & advance, so bubbles propagate as invalid stages.
  - An output beat is consumed when out_valid && out_ready.
- Stage k (k = 0..NSTAGES-1) adds bits [k*STAGE_W +: STAGE_W] of the skewed A and bb, using the carry registered by stage k-1 (c0 for stage 0).
  - It registers the slice sum into the result bits, the carry out, and the untouched upper operand bits.
  - Low result bits already computed shift along unchanged.
- The last stage also registers ovf = carry into MSB XOR carry out of MSB. sum, cout and ovf are direct register outputs.
- Latency: exactly NSTAGES cycles from accept to out_valid with no stall. Throughput is 1 beat/cycle while out_ready=1.
- Stall: while out_valid=1 and out_ready=0:
  - sum, cout, ovf and out_valid are held stable;
  - in_ready=0;
  - no beat is lost or duplicated.
- Simultaneous output consume and input accept in the same cycle is legal and required at full rate.
- Arithmetic is modulo 2^WIDTH; no saturation.
- Reset asserted mid-operation discards all in-flight beats. The first output after reset release corresponds to the first beat accepted after release.
- Elaboration check: WIDTH % STAGE_W != 0 or STAGE_W < 1 → $error.

Decomposition:
- Shared package: NSTAGES derivation function, and a stage-payload struct (skewed a/b remainder, partial sum, carry, valid).
- One sub-module: adder_slice (STAGE_W-bit ripple slice built from the existing full_adder cell; outputs the slice sum, carry out, and the carry into the slice MSB for ovf). Instantiate it NSTAGES times in a generate loop.

Test Plan:
1. WIDTH=8, STAGE_W=2: a=0xFF, b=0x01, cin=0, sub=0 → 4 cycles later sum=0x00, cout=1, ovf=0.
2. a=0x7F, b=0x01, sub=0 → sum=0x80, cout=0, ovf=1. Then a=0x05, b=0x07, sub=1 → sum=0xFE, cout=0, ovf=0.
3. Stream 16 back-to-back beats with out_ready=1 → 16 consecutive out_valid cycles, in order, each matching the reference model.
4. Stream beats, then hold out_ready=0 for 3 cycles mid-stream → in_ready=0 and outputs frozen during the stall. Afterwards all beats are delivered exactly once, in order.
5. Pull rst_n low with 3 beats in flight, then release → out_valid=0 immediately. No stale beat appears. A new beat a=0x10, b=0x20 → sum=0x30 after 4 cycles.
6. Parameter sweep (WIDTH=16/STAGE_W=16, WIDTH=32/STAGE_W=4), random operands with random in_valid/out_ready → latency is 1 and 8 respectively; scoreboard shows zero mismatches over 10k beats.
